// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Holds the FSM state encoding, the byte width and the default divider
// and chip-select hold settings used by spi_master.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_CLK_DIV_DEF = 4;
  localparam int SPI_CS_HOLD_DEF = 2;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, HOLD} spi_mst_state_t;

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, full duplex, byte stream in/out.
// Latency: cs_n falls on the accept edge; the rx byte pulses 16*CLK_DIV cycles later.
// Backpressure: spi_byte_rdy_o is high only in IDLE/WAIT; a byte offered while busy is held off.
// Ports: clk_i/rst_n_i; tx stream spi_byte_{vld,data,last}_i with spi_byte_rdy_o;
//        rx pulse spi_byte_{vld,data}_o; SPI pins spi_sclk_o, spi_mosi_o, spi_cs_n_o, spi_miso_i.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int CS_HOLD = SPI_CS_HOLD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_byte_vld_i,
  input  logic [SPI_BYTE_W-1:0] spi_byte_data_i,
  input  logic                  spi_byte_last_i,
  output logic                  spi_byte_rdy_o,
  output logic                  spi_byte_vld_o,
  output logic [SPI_BYTE_W-1:0] spi_byte_data_o,
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o,
  output logic                  spi_cs_n_o,
  input  logic                  spi_miso_i
);

  localparam logic [7:0] DIV_TC  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_TC = 8'(CS_HOLD - 1);

  spi_mst_state_t        state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            hold_q, hold_d;
  logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
  // Only seven rx bits are ever stored: the eighth goes straight to the output.
  logic [SPI_BYTE_W-2:0] rx_sr_q, rx_sr_d;
  logic                  last_q, last_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  vld_q, vld_d;
  logic [SPI_BYTE_W-1:0] dat_q, dat_d;

  logic accept;
  logic div_tc;
  logic byte_done;

  // Ready is a pure decode of the state register.
  assign spi_byte_rdy_o = (state_q == IDLE) || (state_q == WAIT);
  assign accept         = spi_byte_vld_i & spi_byte_rdy_o;
  assign div_tc         = (div_q == DIV_TC);
  // The eighth falling sclk edge closes the byte.
  assign byte_done      = (state_q == SHIFT) && div_tc && sclk_q && (bit_q == 3'd7);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT: if (accept) state_d = SHIFT;
      SHIFT:      if (byte_done) state_d = last_q ? HOLD : WAIT;
      HOLD:       if (hold_q == HOLD_TC) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and shift/count registers.
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE, WAIT: begin
        sclk_d = 1'b0;
        if (accept) begin
          tx_sr_d = spi_byte_data_i;
          last_d  = spi_byte_last_i;
          mosi_d  = spi_byte_data_i[SPI_BYTE_W-1];
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: miso is taken at the end of the high phase.
            rx_sr_d = {rx_sr_q[SPI_BYTE_W-3:0], spi_miso_i};
            bit_d   = bit_q + 3'd1;
            if (bit_q != 3'd7) begin
              // Rotate so the next bit to send sits in the MSB.
              tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], tx_sr_q[SPI_BYTE_W-1]};
              mosi_d  = tx_sr_q[SPI_BYTE_W-2];
            end else begin
              vld_d  = 1'b1;
              dat_d  = {rx_sr_q, spi_miso_i};
              hold_d = '0;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_TC) cs_n_d = 1'b1;
        else                   hold_d = hold_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign spi_byte_vld_o  = vld_q;
  assign spi_byte_data_o = dat_q;
  assign spi_sclk_o      = sclk_q;
  assign spi_mosi_o      = mosi_q;
  assign spi_cs_n_o      = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a CLK_DIV=2 and a CLK_DIV=1 instance,
// a mode-0 slave model, and tx/rx scoreboards checked by a monitor.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sel = 1'b0;   // 0: observe/drive CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic       vld = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = 8'h00;
  logic       miso = 1'b0;

  logic       vld2, rdy2, vldo2, sclk2, mosi2, csn2;
  logic       vld1, rdy1, vldo1, sclk1, mosi1, csn1;
  logic [7:0] dato2, dato1;

  assign vld2 = vld & ~sel;
  assign vld1 = vld & sel;

  spi_master #(.CLK_DIV(2), .CS_HOLD(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .spi_byte_vld_i(vld2), .spi_byte_data_i(data), .spi_byte_last_i(last),
    .spi_byte_rdy_o(rdy2), .spi_byte_vld_o(vldo2), .spi_byte_data_o(dato2),
    .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_cs_n_o(csn2), .spi_miso_i(miso)
  );

  spi_master #(.CLK_DIV(1), .CS_HOLD(2)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .spi_byte_vld_i(vld1), .spi_byte_data_i(data), .spi_byte_last_i(last),
    .spi_byte_rdy_o(rdy1), .spi_byte_vld_o(vldo1), .spi_byte_data_o(dato1),
    .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_n_o(csn1), .spi_miso_i(miso)
  );

  logic       obs_rdy, obs_vld, obs_sclk, obs_mosi, obs_cs_n;
  logic [7:0] obs_dat;
  assign obs_rdy  = sel ? rdy1  : rdy2;
  assign obs_vld  = sel ? vldo1 : vldo2;
  assign obs_dat  = sel ? dato1 : dato2;
  assign obs_sclk = sel ? sclk1 : sclk2;
  assign obs_mosi = sel ? mosi1 : mosi2;
  assign obs_cs_n = sel ? csn1  : csn2;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_tx_q[$];   // bytes expected on mosi
  logic [7:0] exp_rx_q[$];   // bytes expected on spi_byte_data_o
  logic [7:0] slave_q[$];    // bytes the slave model shifts out

  // Monitor state
  int cyc = 0, sclk_rises = 0, cs_rises = 0, vld_cnt = 0, cs_low_cnt = 0;
  int low_run = 0, max_low_run = 0, mosi0_cnt = 0;
  int last_rise_cyc = -1, period_min = 1000, period_max = 0;
  logic prev_sclk = 1'b0, prev_cs_n = 1'b1;
  logic [7:0] mon_sh = 8'h00;
  int mon_n = 0;
  logic [7:0] sl_tx = 8'h00;
  int sl_n = 0;

  // Monitor + slave model, sampled away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (!obs_cs_n && prev_cs_n) begin
      mon_n = 0;
      sl_n  = 0;
      if (slave_q.size() > 0) sl_tx = slave_q.pop_front();
      else                    sl_tx = 8'h00;
      miso = sl_tx[7];
    end
    if (obs_cs_n && !prev_cs_n) cs_rises++;
    if (!obs_cs_n) begin
      cs_low_cnt++;
      if (!obs_mosi) mosi0_cnt++;
      if (!obs_sclk) low_run++;
    end
    if (obs_sclk && !prev_sclk) begin
      sclk_rises++;
      if (low_run > max_low_run) max_low_run = low_run;
      low_run = 0;
      if (last_rise_cyc >= 0) begin
        if (cyc - last_rise_cyc < period_min) period_min = cyc - last_rise_cyc;
        if (cyc - last_rise_cyc > period_max) period_max = cyc - last_rise_cyc;
      end
      last_rise_cyc = cyc;
      mon_sh = {mon_sh[6:0], obs_mosi};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        n_chk++;
        if (exp_tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL mosi_byte: got %02h, no byte expected", mon_sh);
        end else begin
          e = exp_tx_q.pop_front();
          if (mon_sh !== e) begin
            n_fail++;
            $display("FAIL mosi_byte: got %02h expected %02h", mon_sh, e);
          end
        end
      end
    end
    if (!obs_sclk && prev_sclk && !obs_cs_n) begin
      sl_n++;
      if (sl_n == 8) begin
        sl_n = 0;
        if (slave_q.size() > 0) sl_tx = slave_q.pop_front();
        else                    sl_tx = 8'h00;
      end else begin
        sl_tx = {sl_tx[6:0], 1'b0};
      end
      miso = sl_tx[7];
    end
    if (obs_vld === 1'b1) begin
      vld_cnt++;
      n_chk++;
      if (exp_rx_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_byte: got %02h, no byte expected", obs_dat);
      end else begin
        e = exp_rx_q.pop_front();
        if (obs_dat !== e) begin
          n_fail++;
          $display("FAIL rx_byte: got %02h expected %02h", obs_dat, e);
        end
      end
    end
    prev_sclk = obs_sclk;
    prev_cs_n = obs_cs_n;
  end

  task automatic clear_counters();
    sclk_rises = 0; cs_rises = 0; vld_cnt = 0; cs_low_cnt = 0;
    low_run = 0; max_low_run = 0; mosi0_cnt = 0;
    last_rise_cyc = -1; period_min = 1000; period_max = 0;
  endtask

  // Offer a byte (caller is at a negedge); returns one negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic l, input logic chk);
    int n = 0;
    vld = 1'b1; data = d; last = l;
    while (!obs_rdy && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: rdy stayed %0b, required 1", obs_rdy);
    end else if (chk) begin
      exp_tx_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    vld = 1'b0;
    while (!(obs_cs_n && obs_rdy) && n < 2000) begin @(negedge clk); n++; end
    n_chk++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: cs_n=%0b rdy=%0b, required 1/1", name, obs_cs_n, obs_rdy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({csn2, sclk2, mosi2, vldo2, rdy2} !== 5'b10001 || dato2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_div2: cs/sclk/mosi/vld/rdy=%05b dat=%02h required 10001 00", {csn2, sclk2, mosi2, vldo2, rdy2}, dato2);
    end
    n_chk++;
    if ({csn1, sclk1, mosi1, vldo1, rdy1} !== 5'b10001 || dato1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_div1: cs/sclk/mosi/vld/rdy=%05b dat=%02h required 10001 00", {csn1, sclk1, mosi1, vldo1, rdy1}, dato1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    sel = 1'b0;
    clear_counters();
    slave_q.push_back(8'h6E); exp_rx_q.push_back(8'h6E);
    send(8'h2A, 1'b1, 1'b1);
    wait_idle("single");
    n_chk++; if (sclk_rises !== 8) begin n_fail++; $display("FAIL single_sclk_pulses: got %0d required 8", sclk_rises); end
    n_chk++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL single_vld_pulses: got %0d required 1", vld_cnt); end
    n_chk++; if (cs_low_cnt !== 34) begin n_fail++; $display("FAIL single_cs_low: got %0d required 34", cs_low_cnt); end
    n_chk++; if (obs_rdy !== 1'b1 || obs_dat !== 8'h6E) begin n_fail++; $display("FAIL single_end: rdy=%0b dat=%02h required 1 6e", obs_rdy, obs_dat); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    clear_counters();
    slave_q.push_back(8'h6E); exp_rx_q.push_back(8'h6E);
    slave_q.push_back(8'h6F); exp_rx_q.push_back(8'h6F);
    send(8'h2A, 1'b0, 1'b1);
    send(8'h2B, 1'b1, 1'b1);
    wait_idle("b2b");
    n_chk++; if (cs_rises !== 1) begin n_fail++; $display("FAIL b2b_cs_rises: got %0d required 1", cs_rises); end
    n_chk++; if (sclk_rises !== 16) begin n_fail++; $display("FAIL b2b_sclk_pulses: got %0d required 16", sclk_rises); end
    n_chk++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL b2b_vld_pulses: got %0d required 2", vld_cnt); end
    // Longest sclk-low stretch is the 1-cycle WAIT gap plus a CLK_DIV low phase.
    n_chk++; if (max_low_run !== 3) begin n_fail++; $display("FAIL b2b_gap: got %0d required 3", max_low_run); end
  endtask

  task automatic test_stall();
    int n = 0;
    sel = 1'b0;
    clear_counters();
    slave_q.push_back(8'h6E); exp_rx_q.push_back(8'h6E);
    slave_q.push_back(8'h5A); exp_rx_q.push_back(8'h5A);
    send(8'h2A, 1'b0, 1'b1);
    vld = 1'b0;
    while (!obs_rdy && n < 2000) begin @(negedge clk); n++; end
    for (int i = 0; i < 50; i++) begin
      n_chk++;
      if ({obs_cs_n, obs_sclk, obs_rdy} !== 3'b001) begin
        n_fail++;
        $display("FAIL stall_wait: cs/sclk/rdy=%03b required 001 at cycle %0d", {obs_cs_n, obs_sclk, obs_rdy}, i);
      end
      @(negedge clk);
    end
    send(8'h00, 1'b1, 1'b1);
    wait_idle("stall");
    n_chk++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL stall_vld_pulses: got %0d required 2", vld_cnt); end
  endtask

  task automatic test_busy();
    int n = 0;
    sel = 1'b0;
    clear_counters();
    slave_q.push_back(8'h11); exp_rx_q.push_back(8'h11);
    slave_q.push_back(8'h22); exp_rx_q.push_back(8'h22);
    send(8'h55, 1'b0, 1'b1);
    while (!obs_rdy && n < 200) begin
      data = 8'($urandom);
      last = 1'($urandom);
      @(negedge clk);
      n++;
    end
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL busy_cycles: got %0d required 32", n); end
    send(8'hC3, 1'b1, 1'b1);
    wait_idle("busy");
    n_chk++; if (sclk_rises !== 16) begin n_fail++; $display("FAIL busy_sclk_pulses: got %0d required 16", sclk_rises); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int v0;
    sel = 1'b0;
    clear_counters();
    send(8'hE7, 1'b1, 1'b0);
    vld = 1'b0;
    while (sclk_rises < 3 && n < 2000) begin @(negedge clk); n++; end
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({csn2, sclk2, mosi2, vldo2, rdy2} !== 5'b10001 || dato2 !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outputs: cs/sclk/mosi/vld/rdy=%05b dat=%02h required 10001 00", {csn2, sclk2, mosi2, vldo2, rdy2}, dato2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (vld_cnt !== v0) begin n_fail++; $display("FAIL midreset_partial: got %0d pulses required %0d", vld_cnt, v0); end
    slave_q.push_back(8'hC5); exp_rx_q.push_back(8'hC5);
    send(8'h3C, 1'b1, 1'b1);
    wait_idle("midreset");
    n_chk++; if (vld_cnt !== v0 + 1 || obs_dat !== 8'hC5) begin n_fail++; $display("FAIL midreset_after: pulses=%0d dat=%02h required %0d c5", vld_cnt, obs_dat, v0 + 1); end
  endtask

  task automatic test_clkdiv1();
    sel = 1'b1;
    @(negedge clk);
    clear_counters();
    slave_q.push_back(8'hFF); exp_rx_q.push_back(8'hFF);
    send(8'hFF, 1'b1, 1'b1);
    wait_idle("div1");
    n_chk++; if (sclk_rises !== 8) begin n_fail++; $display("FAIL div1_sclk_pulses: got %0d required 8", sclk_rises); end
    n_chk++; if (period_min !== 2 || period_max !== 2) begin n_fail++; $display("FAIL div1_period: got %0d..%0d required 2..2", period_min, period_max); end
    n_chk++; if (mosi0_cnt !== 0) begin n_fail++; $display("FAIL div1_mosi_const: got %0d low cycles required 0", mosi0_cnt); end
    n_chk++; if (cs_low_cnt !== 18) begin n_fail++; $display("FAIL div1_cs_low: got %0d required 18", cs_low_cnt); end
    n_chk++; if (vld_cnt !== 1 || dato1 !== 8'hFF) begin n_fail++; $display("FAIL div1_rx: pulses=%0d dat=%02h required 1 ff", vld_cnt, dato1); end
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_busy();
    test_reset_mid();
    test_clkdiv1();
    repeat (4) @(negedge clk);
    n_chk++; if (exp_tx_q.size() !== 0) begin n_fail++; $display("FAIL tx_left: got %0d bytes required 0", exp_tx_q.size()); end
    n_chk++; if (exp_rx_q.size() !== 0) begin n_fail++; $display("FAIL rx_left: got %0d bytes required 0", exp_rx_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
